// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack: renormalises a raw adder sum one bit per cycle and packs {sign, exp, mant} with flags
module fp_normalize_pack #(
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sign,
    input  logic [E_WIDTH-1:0]           in_exp,
    input  logic [M_WIDTH+1:0]           in_mant,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [E_WIDTH+M_WIDTH:0]     out_data,
    output logic                         out_zero,
    output logic                         out_ovf,
    output logic                         out_unf
);
    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;
    localparam logic [E_WIDTH:0] EXP_ONE = E_WIDTH'(1);
    localparam logic [E_WIDTH:0] EXP_MAX = {1'b0, {E_WIDTH{1'b1}}};
    state_t               state;
    logic                 sign;
    logic [E_WIDTH:0]     exp;
    logic [M_WIDTH+1:0]   mant;
    logic [E_WIDTH:0]     exp_inc;
    logic [E_WIDTH:0]     exp_dec;
    logic [M_WIDTH:0]     shl;
    assign exp_inc   = exp + EXP_ONE;
    assign exp_dec   = exp - EXP_ONE;
    assign shl       = {mant[M_WIDTH-1:0], 1'b0};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    // Control FSM plus datapath: the shift loop stops at the hidden bit or at the smallest exponent, never below it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sign     <= 1'b0;
            exp      <= '0;
            mant     <= '0;
            out_data <= '0;
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
            out_unf  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign     <= in_sign;
                    exp      <= (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
                    mant     <= in_mant;
                    out_zero <= 1'b0;
                    out_ovf  <= 1'b0;
                    out_unf  <= 1'b0;
                    state    <= CHECK;
                end
                CHECK: begin
                    if (mant == '0) begin
                        out_data <= {sign, {(E_WIDTH+M_WIDTH){1'b0}}};
                        out_zero <= 1'b1;
                        state    <= DONE;
                    end else if (mant[M_WIDTH+1]) begin
                        if (exp_inc >= EXP_MAX) begin
                            out_data <= {sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
                            out_ovf  <= 1'b1;
                        end else begin
                            out_data <= {sign, exp_inc[E_WIDTH-1:0], mant[M_WIDTH:1]};
                        end
                        state <= DONE;
                    end else if (mant[M_WIDTH]) begin
                        out_data <= {sign, exp[E_WIDTH-1:0], mant[M_WIDTH-1:0]};
                        state    <= DONE;
                    end else if (exp == EXP_ONE) begin
                        out_data <= {sign, {E_WIDTH{1'b0}}, mant[M_WIDTH-1:0]};
                        out_unf  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    mant <= {1'b0, shl};
                    exp  <= exp_dec;
                    if (shl[M_WIDTH]) begin
                        out_data <= {sign, exp_dec[E_WIDTH-1:0], shl[M_WIDTH-1:0]};
                        state    <= DONE;
                    end else if (exp_dec == EXP_ONE) begin
                        out_data <= {sign, {E_WIDTH{1'b0}}, shl[M_WIDTH-1:0]};
                        out_unf  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_normalize_pack.sv
// tb_fp_normalize_pack: directed and randomized checks of the normalise/pack stage against an arithmetic model
module tb_fp_normalize_pack;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [24:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;
    int vectors = 0;
    int errs = 0;

    fp_normalize_pack #(.E_WIDTH(8), .M_WIDTH(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference: plain integer arithmetic on value and exponent
    task automatic model(input logic s, input int e_in, input int m_in,
                         output logic [31:0] data, output logic [2:0] flags, output int lat);
        int e, m, k, field;
        e = (e_in == 0) ? 1 : e_in;
        m = m_in;
        k = 0;
        flags = 3'b000;
        if (m == 0) begin
            data = {s, 31'd0};
            flags = 3'b100;
        end else if (m >= (1 << 24)) begin
            m = m / 2;
            e = e + 1;
            if (e >= 255) begin
                data = {s, 8'hFF, 23'd0};
                flags = 3'b010;
            end else begin
                data = {s, 8'(e), 23'(m % (1 << 23))};
            end
        end else begin
            while (m < (1 << 23) && e > 1) begin
                m = m * 2;
                e = e - 1;
                k++;
            end
            field = (m < (1 << 23)) ? 0 : e;
            if (m < (1 << 23)) flags = 3'b001;
            data = {s, 8'(field), 23'(m % (1 << 23))};
        end
        lat = 1 + k;
    endtask

    task automatic txn(input logic s, input logic [7:0] e, input logic [24:0] m, input int hold);
        logic [31:0] want;
        logic [2:0]  wflags;
        int          wlat, lat;
        model(s, int'(e), int'(m), want, wflags, wlat);
        @(negedge clk);
        check("ready_before", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_sign = s;
        in_exp = e;
        in_mant = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mant = 25'h1FFFFFF;
        in_exp = 8'hFF;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(wlat));
        check("out_valid", 64'(out_valid), 64'd1);
        check("out_data", 64'(out_data), 64'(want));
        check("flags", 64'({out_zero, out_ovf, out_unf}), 64'(wflags));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_mant = 25'($urandom);
            @(posedge clk);
            #1;
            check("hold_data", 64'({out_valid, in_ready, out_data}), 64'({2'b10, want}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release", 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic [24:0] m;
        logic [7:0]  e;
        #1;
        check("reset_state", 64'({in_ready, out_valid, out_zero, out_ovf, out_unf, out_data}), 64'({5'b10000, 32'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 8'd127, 25'h0800000, 0);
        txn(1'b0, 8'd127, 25'h1000000, 0);
        txn(1'b0, 8'd127, 25'h0200000, 0);
        txn(1'b0, 8'd254, 25'h1000000, 0);
        txn(1'b1, 8'd127, 25'h0000000, 0);
        txn(1'b0, 8'd3,   25'h0000001, 0);
        txn(1'b0, 8'd0,   25'h0800000, 0);
        txn(1'b1, 8'd1,   25'h0012345, 0);
        txn(1'b0, 8'd127, 25'h0000001, 0);
        txn(1'b1, 8'd100, 25'h1ABCDEF, 5);
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: m = 25'd0;
                1: m = {1'b1, 24'($urandom)};
                2: m = {2'b01, 23'($urandom)};
                default: begin
                    m = {2'b00, 23'($urandom)} >> $urandom_range(0, 22);
                    if (m == 25'd0) m = 25'd1;
                end
            endcase
            e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 254));
            txn(1'($urandom), e, m, $urandom_range(0, 3));
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_sign = 1'b0;
        in_exp = 8'd127;
        in_mant = 25'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_shift_busy", 64'({in_ready, out_valid}), 64'b00);
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({in_ready, out_valid, out_data}), 64'({2'b10, 32'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 8'd127, 25'h0800000, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
